// File: rtl/ualink_mac_dot4.sv
// Four-lane unsigned dot-product engine: captures two 64-bit words, accumulates one lane product
// per cycle. Optional saturating accumulator via `define MAC_SATURATE_EN (default: wrap-around).
module ualink_mac_dot4 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARRAY_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_mac,
    input  logic [63:0]               doutb_a,
    input  logic [63:0]               doutb_b,
    output logic [2*DATA_WIDTH-1:0]   mac_result,
    output logic                      status_done
);

    localparam int unsigned NumLanes = 64 / DATA_WIDTH;
    localparam int unsigned AccW     = 2 * DATA_WIDTH;
    localparam int unsigned IdxW     = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLanes - 1);

    // Elaboration-time sanity check on the configuration.
    if ((64 % DATA_WIDTH) != 0 || ARRAY_SIZE == 0) begin : g_bad_cfg
        $error("ualink_mac_dot4: DATA_WIDTH must divide 64 and ARRAY_SIZE must be nonzero");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       opa_q, opa_d;
    logic [63:0]       opb_q, opb_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [AccW-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic [DATA_WIDTH-1:0] lane_a [NumLanes];
    logic [DATA_WIDTH-1:0] lane_b [NumLanes];
    logic [AccW-1:0]       prod;
    logic [AccW-1:0]       acc_next;

    always_comb begin
        for (int k = 0; k < int'(NumLanes); k++) begin
            lane_a[k] = opa_q[k*DATA_WIDTH +: DATA_WIDTH];
            lane_b[k] = opb_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign prod = AccW'(lane_a[idx_q]) * AccW'(lane_b[idx_q]);

`ifdef MAC_SATURATE_EN
    logic [AccW:0] sum_ext;

    // Products are non-negative, so once pinned at all-ones the sum stays there.
    always_comb begin
        sum_ext  = {1'b0, acc_q} + {1'b0, prod};
        acc_next = sum_ext[AccW] ? {AccW{1'b1}} : sum_ext[AccW-1:0];
    end
`else
    assign acc_next = acc_q + prod;
`endif

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            StIdle, StDone: begin
                if (start_mac) begin
                    opa_d   = doutb_a;
                    opb_d   = doutb_b;
                    acc_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                // start_mac is deliberately ignored until the last lane is folded in.
                acc_d = acc_next;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    result_d = acc_next;
                    done_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign mac_result  = result_q;
    assign status_done = done_q;

endmodule

// File: tb/tb_ualink_mac_dot4.sv
// Self-checking bench for ualink_mac_dot4: directed patterns, control corners and random
// operands compared against a plain-arithmetic dot-product model.
module tb_ualink_mac_dot4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_mac;
    logic [63:0] doutb_a;
    logic [63:0] doutb_b;
    logic [31:0] mac_result;
    logic        status_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ualink_mac_dot4 #(
        .DATA_WIDTH (16),
        .ARRAY_SIZE (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_mac   (start_mac),
        .doutb_a     (doutb_a),
        .doutb_b     (doutb_b),
        .mac_result  (mac_result),
        .status_done (status_done)
    );

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: exact sum of lane products, then reduced to 32 bits.
    function automatic logic [31:0] ref_dot(input logic [63:0] a, input logic [63:0] b);
        longint unsigned s;
        longint unsigned la;
        longint unsigned lb;
        logic [63:0]     s_bits;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            la = longint'(a[k*16 +: 16]);
            lb = longint'(b[k*16 +: 16]);
            s  = s + la * lb;
        end
`ifdef MAC_SATURATE_EN
        if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
`endif
        s_bits = s;
        return s_bits[31:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with a one-cycle start pulse; returns just after the start edge.
    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        doutb_a   = a;
        doutb_b   = b;
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
    endtask

    // Bounded wait for status_done; cycles counts edges waited.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!status_done && cycles < 12) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start_mac = 1'b1;
        doutb_a   = rand64();
        doutb_b   = rand64();
        tick();
        tick();
        total++;
        if (mac_result !== 32'd0 || status_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: result=%h done=%b want result=0 done=0",
                     mac_result, status_done);
        end
        rst       = 1'b1;
        start_mac = 1'b0;
        repeat (6) tick();
        total++;
        if (mac_result !== 32'd0 || status_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_wins_start: result=%h done=%b want result=0 done=0",
                     mac_result, status_done);
        end
    endtask

    task automatic test_sequential();
        int c;
        total++;
        if (status_done !== 1'b0) begin
            bad++;
            $display("FAIL seq_done_before: done=%b want 0", status_done);
        end
        launch(pack4(1, 2, 3, 4), pack4(2, 3, 4, 5));
        total++;
        if (status_done !== 1'b0) begin
            bad++;
            $display("FAIL seq_done_at_start: done=%b want 0", status_done);
        end
        tick();
        total++;
        if (status_done !== 1'b0) begin
            bad++;
            $display("FAIL seq_done_plus1: done=%b want 0", status_done);
        end
        wait_done(c);
        total++;
        if (c + 1 !== 4) begin
            bad++;
            $display("FAIL seq_latency: got %0d cycles want 4", c + 1);
        end
        total++;
        if (mac_result !== 32'd40 || status_done !== 1'b1) begin
            bad++;
            $display("FAIL seq_result: result=%0d done=%b want 40 done=1",
                     mac_result, status_done);
        end
    endtask

    task automatic test_patterns();
        logic [63:0] pa [4];
        logic [63:0] pb [4];
        logic [31:0] pe [4];
        int          c;
        pa[0] = 64'd0;                      pb[0] = 64'd0;                      pe[0] = 32'd0;
        pa[1] = pack4(1, 1, 1, 1);          pb[1] = pack4(1, 1, 1, 1);          pe[1] = 32'd4;
        pa[2] = pack4(1, 2, 1, 2);          pb[2] = pack4(3, 4, 3, 4);          pe[2] = 32'd22;
        pa[3] = {64{1'b1}};                 pb[3] = {64{1'b1}};
`ifdef MAC_SATURATE_EN
        pe[3] = 32'hFFFF_FFFF;
`else
        pe[3] = 32'hFFF8_0004;
`endif
        for (int i = 0; i < 4; i++) begin
            launch(pa[i], pb[i]);
            wait_done(c);
            total++;
            if (c !== 4 || mac_result !== pe[i] || status_done !== 1'b1) begin
                bad++;
                $display("FAIL pattern_%0d: result=%h done=%b lat=%0d want result=%h done=1 lat=4",
                         i, mac_result, status_done, c, pe[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] exp;
        int          c;
        for (int i = 0; i < 16; i++) begin
            a = rand64();
            b = rand64();
            if (i % 4 == 0) a = a | 64'hFFF0_FFF0_FFF0_FFF0;
            exp = ref_dot(a, b);
            launch(a, b);
            wait_done(c);
            total++;
            if (c !== 4 || mac_result !== exp) begin
                bad++;
                $display("FAIL random_%0d: result=%h lat=%0d want result=%h lat=4",
                         i, mac_result, c, exp);
            end
        end
    endtask

    task automatic test_start_held();
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] exp;
        int          glitch;
        a   = pack4(7, 9, 11, 13);
        b   = pack4(100, 200, 300, 400);
        exp = ref_dot(a, b);
        doutb_a   = a;
        doutb_b   = b;
        start_mac = 1'b1;
        tick();
        doutb_a = rand64();
        doutb_b = rand64();
        tick();
        tick();
        start_mac = 1'b0;
        tick();
        total++;
        if (status_done !== 1'b0) begin
            bad++;
            $display("FAIL held_done_early: done=%b want 0", status_done);
        end
        tick();
        total++;
        if (status_done !== 1'b1 || mac_result !== exp) begin
            bad++;
            $display("FAIL held_complete: result=%h done=%b want result=%h done=1",
                     mac_result, status_done, exp);
        end
        glitch = 0;
        repeat (6) begin
            tick();
            if (status_done !== 1'b1 || mac_result !== exp) glitch++;
        end
        total++;
        if (glitch !== 0) begin
            bad++;
            $display("FAIL held_single_op: %0d disturbed cycles want 0", glitch);
        end
    endtask

    task automatic test_reset_mid_acc();
        int dirty;
        launch(pack4(5, 6, 7, 8), pack4(9, 9, 9, 9));
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if (mac_result !== 32'd0 || status_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_acc: result=%h done=%b want result=0 done=0",
                     mac_result, status_done);
        end
        dirty = 0;
        repeat (6) begin
            tick();
            if (mac_result !== 32'd0 || status_done !== 1'b0) dirty++;
        end
        total++;
        if (dirty !== 0) begin
            bad++;
            $display("FAIL reset_abort: %0d cycles with a result want 0", dirty);
        end
    endtask

    task automatic test_operand_change();
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] exp;
        int          c;
        a   = pack4(16'h1234, 16'h00FF, 16'h0F0F, 16'h8001);
        b   = pack4(16'h0003, 16'h0101, 16'h0022, 16'h0007);
        exp = ref_dot(a, b);
        launch(a, b);
        doutb_a = ~a;
        doutb_b = ~b;
        tick();
        doutb_a = rand64();
        doutb_b = rand64();
        wait_done(c);
        total++;
        if (c + 1 !== 4 || mac_result !== exp) begin
            bad++;
            $display("FAIL operand_change: result=%h lat=%0d want result=%h lat=4",
                     mac_result, c + 1, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1;
        logic [63:0] b1;
        logic [63:0] a2;
        logic [63:0] b2;
        logic [31:0] r1;
        logic [31:0] r2;
        int          c;
        int          stale;
        a1 = pack4(3, 3, 3, 3);
        b1 = pack4(10, 20, 30, 40);
        r1 = ref_dot(a1, b1);
        launch(a1, b1);
        wait_done(c);
        a2 = pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        b2 = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        r2 = ref_dot(a2, b2);
        launch(a2, b2);
        total++;
        if (status_done !== 1'b0 || mac_result !== r1) begin
            bad++;
            $display("FAIL restart_edge: result=%h done=%b want result=%h done=0",
                     mac_result, status_done, r1);
        end
        stale = 0;
        repeat (3) begin
            tick();
            if (status_done !== 1'b0 || mac_result !== r1) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL restart_hold_old: %0d bad cycles want 0", stale);
        end
        tick();
        total++;
        if (status_done !== 1'b1 || mac_result !== r2) begin
            bad++;
            $display("FAIL restart_complete: result=%h done=%b want result=%h done=1",
                     mac_result, status_done, r2);
        end
    endtask

    initial begin
        rst       = 1'b0;
        start_mac = 1'b0;
        doutb_a   = '0;
        doutb_b   = '0;
        test_reset();
        test_sequential();
        test_patterns();
        test_random();
        test_start_held();
        test_reset_mid_acc();
        test_operand_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
